// File: rtl/msg_padder.sv
// Message padder: collects a byte stream into 64-byte blocks and appends the
// 0x80 marker, zero fill and the 64-bit big-endian bit length. It then streams
// each 16-word block to the message scheduler.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/in_valid/   byte input; a byte is taken when in_valid && in_ready
//   in_last/in_ready
//   blk_rdy             scheduler can take a block (only looked at in WAIT)
//   M_o/M_dv            registered big-endian word output, 16 consecutive words
//   M_first/M_final     word 0 marker / last-block-of-message marker
module msg_padder (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   input  logic        blk_rdy,
   output logic [31:0] M_o,
   output logic        M_dv,
   output logic        M_first,
   output logic        M_final
);
   localparam int unsigned WORD_W = 32;
   localparam int unsigned NWORDS = 16;
   localparam int unsigned PTR_W  = 6;
   localparam int unsigned LEN_W  = 64;
   localparam int unsigned WCNT_W = 4;

   typedef enum logic [2:0] {IDLE, FILL, PAD, ZERO, LEN, WAIT, SEND} state_t;

   state_t              state, nxt, ret, ret_nxt;
   logic [WORD_W-1:0]   blk [NWORDS];
   logic [PTR_W-1:0]    ptr, ptr_nxt;
   logic [LEN_W-1:0]    len, len_nxt, len_sh;
   logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
   logic                fin, fin_nxt;
   logic                wr_en;
   logic [7:0]          wr_byte;
   logic [WORD_W-1:0]   m_o_nxt;
   logic                m_dv_nxt, m_first_nxt, m_final_nxt;
   logic                acc;

   assign acc = in_valid && in_ready;

   // Length byte for slot 56..63: slot 56 carries the most significant byte.
   assign len_sh = len >> {3'(3'd7 - ptr[2:0]), 3'b000};

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ret      <= IDLE;
         ptr      <= '0;
         len      <= '0;
         wcnt     <= '0;
         fin      <= 1'b0;
         in_ready <= 1'b0;
         M_o      <= '0;
         M_dv     <= 1'b0;
         M_first  <= 1'b0;
         M_final  <= 1'b0;
      end else begin
         state    <= nxt;
         ret      <= ret_nxt;
         ptr      <= ptr_nxt;
         len      <= len_nxt;
         wcnt     <= wcnt_nxt;
         fin      <= fin_nxt;
         in_ready <= (nxt == FILL);
         M_o      <= m_o_nxt;
         M_dv     <= m_dv_nxt;
         M_first  <= m_first_nxt;
         M_final  <= m_final_nxt;
      end
   end

   // Block buffer: byte k lands in word k/4, most significant byte first.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         case (ptr[1:0])
            2'd0:    blk[ptr[5:2]][31:24] <= wr_byte;
            2'd1:    blk[ptr[5:2]][23:16] <= wr_byte;
            2'd2:    blk[ptr[5:2]][15:8]  <= wr_byte;
            default: blk[ptr[5:2]][7:0]   <= wr_byte;
         endcase
      end
   end

   // Next-state, buffer write and output selection.
   always_comb begin
      nxt         = state;
      ret_nxt     = ret;
      ptr_nxt     = ptr;
      len_nxt     = len;
      wcnt_nxt    = wcnt;
      fin_nxt     = fin;
      wr_en       = 1'b0;
      wr_byte     = '0;
      m_o_nxt     = '0;
      m_dv_nxt    = 1'b0;
      m_first_nxt = 1'b0;
      m_final_nxt = 1'b0;
      case (state)
         IDLE: nxt = FILL;
         FILL: begin
            if (acc) begin
               wr_en   = 1'b1;
               wr_byte = in_data;
               ptr_nxt = ptr + PTR_W'(1);
               len_nxt = len + LEN_W'(8);
               if (ptr == PTR_W'(63)) begin
                  nxt     = WAIT;
                  ret_nxt = in_last ? PAD : FILL;
               end else if (in_last) begin
                  nxt = PAD;
               end
            end
         end
         PAD: begin
            wr_en   = 1'b1;
            wr_byte = 8'h80;
            ptr_nxt = ptr + PTR_W'(1);
            if (ptr == PTR_W'(63)) begin
               nxt     = WAIT;
               ret_nxt = ZERO;
            end else begin
               nxt = ZERO;
            end
         end
         ZERO: begin
            if (ptr == PTR_W'(56)) begin
               nxt = LEN;
            end else begin
               wr_en   = 1'b1;
               ptr_nxt = ptr + PTR_W'(1);
               if (ptr == PTR_W'(63)) begin
                  nxt     = WAIT;
                  ret_nxt = ZERO;
               end
            end
         end
         LEN: begin
            wr_en   = 1'b1;
            wr_byte = len_sh[7:0];
            ptr_nxt = ptr + PTR_W'(1);
            if (ptr == PTR_W'(63)) begin
               nxt     = WAIT;
               ret_nxt = FILL;
               fin_nxt = 1'b1;
            end
         end
         WAIT: begin
            if (blk_rdy) begin
               nxt      = SEND;
               wcnt_nxt = '0;
            end
         end
         SEND: begin
            m_o_nxt     = blk[wcnt];
            m_dv_nxt    = 1'b1;
            m_first_nxt = (wcnt == '0);
            m_final_nxt = fin;
            wcnt_nxt    = wcnt + WCNT_W'(1);
            if (wcnt == WCNT_W'(15)) begin
               nxt = ret;
               // Final block done: start the next message's length from zero.
               if (fin) begin
                  len_nxt = '0;
                  fin_nxt = 1'b0;
               end
            end
         end
         default: nxt = IDLE;
      endcase
   end
endmodule
